// File: rtl/exponent_logic_if.sv
// Operand/result bundle for the FP exponent unit.
//   eA, eB : biased 8-bit operand exponents
//   en     : result register load enable
//   sel    : 0 = multiply, 1 = divide
//   e      : registered 10-bit two's-complement result exponent
interface exponent_logic_if;
  logic [7:0] eA;
  logic [7:0] eB;
  logic       en;
  logic       sel;
  logic [9:0] e;

  // Operand source drives inputs and observes the result
  modport master (
    output eA,
    output eB,
    output en,
    output sel,
    input  e
  );

  // Exponent unit consumes operands and drives the result
  modport slave (
    input  eA,
    input  eB,
    input  en,
    input  sel,
    output e
  );
endinterface

// File: rtl/exponent_logic.sv
// Exponent datapath for single-precision multiply/divide.
// Computes eA + eB - BIAS (multiply) or eA - eB + BIAS (divide) modulo 2^10
// and registers it on enabled clock edges. No clamping is applied, so
// underflow (<= 0) and overflow (>= 255) pass through for downstream checks.
//   clk  : clock, rising edge
//   arst : asynchronous active-low reset, clears e
//   bus  : exponent_logic_if.slave (eA, eB, en, sel in; e out)
module exponent_logic #(
  parameter int BIAS = 127
) (
  input logic              clk,
  input logic              arst,
  exponent_logic_if.slave  bus
);

  localparam int unsigned RW = 10;
  localparam logic [RW-1:0] BIAS_EXT = RW'(BIAS);

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [RW-1:0] next_e_c;

  // Zero-extend operands and form the next result, wrapping mod 2^10
  always_comb begin
    a_ext    = RW'(bus.eA);
    b_ext    = RW'(bus.eB);
    next_e_c = '0;
    if (bus.sel) begin
      next_e_c = a_ext - b_ext + BIAS_EXT;
    end else begin
      next_e_c = a_ext + b_ext - BIAS_EXT;
    end
  end

  // Result register; reset dominates the load enable
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      bus.e <= '0;
    end else if (bus.en) begin
      bus.e <= next_e_c;
    end
  end

endmodule

// File: tb/tb_exponent_logic.sv
// Directed and random checks for exponent_logic.
module tb_exponent_logic;

  logic clk;
  logic arst;
  int   total;
  int   bad;

  exponent_logic_if bus ();

  exponent_logic #(.BIAS(127)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply operands at the falling edge, then sample just after the next rising edge
  task automatic apply(input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic enable);
    @(negedge clk);
    bus.eA  = a;
    bus.eB  = b;
    bus.sel = s;
    bus.en  = enable;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst    = 1'b0;
    bus.eA  = 8'd0;
    bus.eB  = 8'd0;
    bus.sel = 1'b0;
    bus.en  = 1'b0;
    #1;
    total++;
    if (bus.e !== 10'h000) begin
      bad++;
      $display("FAIL reset_initial: got %h want 000", bus.e);
    end
    @(negedge clk);
    arst = 1'b1;
    apply(8'd127, 8'd127, 1'b0, 1'b1);
    total++;
    if (bus.e !== 10'h07F) begin
      bad++;
      $display("FAIL reset_preload: got %h want 07f", bus.e);
    end
    // Assert reset between edges: output must clear without a clock
    @(negedge clk);
    #2;
    arst = 1'b0;
    #1;
    total++;
    if (bus.e !== 10'h000) begin
      bad++;
      $display("FAIL reset_async: got %h want 000", bus.e);
    end
    for (int i = 0; i < 4; i++) begin
      apply(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      total++;
      if (bus.e !== 10'h000) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %h want 000", i, bus.e);
      end
    end
    @(negedge clk);
    bus.en = 1'b0;
    arst   = 1'b1;
    // First enabled edge after release loads the computed value
    apply(8'd140, 8'd20, 1'b0, 1'b1);
    total++;
    if (bus.e !== 10'h021) begin
      bad++;
      $display("FAIL reset_release_load: got %h want 021", bus.e);
    end
  endtask

  task automatic test_multiply();
    logic [7:0] va [3] = '{8'd127, 8'd0,   8'd255};
    logic [7:0] vb [3] = '{8'd127, 8'd0,   8'd255};
    logic [9:0] ve [3] = '{10'h07F, 10'h381, 10'h17F};
    for (int i = 0; i < 3; i++) begin
      apply(va[i], vb[i], 1'b0, 1'b1);
      total++;
      if (bus.e !== ve[i]) begin
        bad++;
        $display("FAIL mul[%0d] a=%0d b=%0d: got %h want %h", i, va[i], vb[i], bus.e, ve[i]);
      end
    end
  endtask

  task automatic test_divide();
    logic [7:0] va [3] = '{8'd0,    8'd255,  8'd100};
    logic [7:0] vb [3] = '{8'd255,  8'd0,    8'd100};
    logic [9:0] ve [3] = '{10'h380, 10'h17E, 10'h07F};
    for (int i = 0; i < 3; i++) begin
      apply(va[i], vb[i], 1'b1, 1'b1);
      total++;
      if (bus.e !== ve[i]) begin
        bad++;
        $display("FAIL div[%0d] a=%0d b=%0d: got %h want %h", i, va[i], vb[i], bus.e, ve[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    apply(8'd130, 8'd127, 1'b0, 1'b1);
    total++;
    if (bus.e !== 10'd130) begin
      bad++;
      $display("FAIL hold_load: got %h want %h", bus.e, 10'd130);
    end
    for (int i = 0; i < 5; i++) begin
      apply(8'(10 + 37 * i), 8'(200 - 11 * i), 1'(i), 1'b0);
      total++;
      if (bus.e !== 10'd130) begin
        bad++;
        $display("FAIL hold[%0d]: got %h want %h", i, bus.e, 10'd130);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [9:0] exp_e;
    for (int i = 0; i < 520; i++) begin
      if (i == 260) begin
        // Mid-run reset pulse between edges
        arst = 1'b0;
        #1;
        total++;
        if (bus.e !== 10'h000) begin
          bad++;
          $display("FAIL rand_reset: got %h want 000", bus.e);
        end
        @(negedge clk);
        arst = 1'b1;
      end
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      if (s) exp_e = 10'(int'(a) - int'(b) + 127);
      else   exp_e = 10'(int'(a) + int'(b) - 127);
      apply(a, b, s, 1'b1);
      total++;
      if (bus.e !== exp_e) begin
        bad++;
        $display("FAIL rand[%0d] a=%0d b=%0d sel=%0d: got %h want %h", i, a, b, s, bus.e, exp_e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_multiply();
    test_divide();
    test_enable_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
